md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit with HI/LO registers for the execute stage of the pipelined MIPS core. It replaces the fixed-width, behavioural multiply/divide block. Divides run as a real iterative restoring divider; multiplies run as a fixed-latency pipeline. Madd/msub accumulate in both signed and unsigned forms, and an in-flight operation can be cancelled on an exception. It reports busy and a decode-stage stall, and drives HI/LO to the E-stage result mux for mfhi/mflo.

## Interface
- WIDTH, 32: operand, HI and LO width; a product is 2*WIDTH.
- MUL_LAT, 5: busy cycles for mult/multu/madd/maddu/msub/msubu; must be ≥1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  E-stage op valid this cycle.
- op_e  in  4  E-stage op code.
- op_d  in  4  D-stage op code; used only for the stall output.
- cancel  in  1  abort the in-flight op and any op starting this cycle.
- rs  in  WIDTH  operand A (dividend, multiplicand, mthi/mtlo source).
- rt  in  WIDTH  operand B (divisor, multiplier).
- busy  out  1  an operation is in flight.
- stall_d  out  1  D-stage must hold.
- rdata  out  WIDTH  HI when op_e=8, LO when op_e=7, otherwise 0; combinational.
- hi, lo  out  WIDTH  architectural HI/LO registers.

## Operation
- Op codes:
  - 0 none; 1 mtlo; 2 mthi; 3 divu; 4 div; 5 multu; 6 mult; 7 mflo; 8 mfhi.
  - 9 madd; 10 maddu; 11 msub; 12 msubu.
  - 13–15 are treated as 0.
- Long ops are codes 3–6 and 9–12. A long op is accepted when start=1, busy=0 and cancel=0. rs and rt are captured into internal registers at acceptance.
- Reset values: hi=0, lo=0, busy=0. The FSM is in IDLE and all internal counters and registers are 0.
- FSM states:
  - IDLE → MUL when a mul-class op is accepted.
  - IDLE → DIV when a div-class op is accepted.
  - MUL → IDLE after MUL_LAT cycles.
  - DIV → FIX after WIDTH iterations, one quotient bit per cycle.
  - FIX → IDLE after 1 cycle; FIX applies the signed correction and writes HI/LO.
- Multiply results:
  - mult: {hi,lo} = signed rs × signed rt.
  - multu: {hi,lo} = unsigned rs × unsigned rt.
  - madd/maddu: {hi,lo} += product (signed/unsigned product); HI/LO are sampled at completion, not at start.
  - msub/msubu: {hi,lo} −= product.
  - All arithmetic is modulo 2^(2*WIDTH).
- Divide results:
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Division by zero (div and divu): lo = all ones, hi = rs.
  - div of MIN by −1: lo = MIN, hi = 0.
- mthi/mtlo with start=1 and busy=0 write HI/LO at that edge, with no busy cycle.
- Any op presented with start=1 while busy=1 is ignored. Upstream guarantees this does not happen via stall_d.
- cancel=1 while busy: the FSM returns to IDLE at that edge, HI/LO are unchanged, and busy=0 on the next cycle. cancel with start blocks the start. cancel in IDLE has no effect.
- reset mid-operation returns the unit to its reset values. No partial result is written.

## Timing
- Long op accepted at edge T0: busy=1 from T0 until the completion edge.
- MUL: HI/LO are written and busy falls at edge T0+MUL_LAT.
- DIV: HI/LO are written and busy falls at edge T0+WIDTH+1.
- mfhi/mflo in E in the first cycle with busy=0 sees the new HI/LO.
- stall_d = (op_d ∈ 1..12) && (busy || (start && op_e is long && !cancel)).
- HI/LO are never written on any edge other than mthi/mtlo or op completion.

## Test plan
- mult rs=0xFFFFFFFE (−2), rt=3 -> busy for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat as multu -> hi=0x00000002, lo=0xFFFFFFFA.
- div rs=−7, rt=2 -> busy for 33 cycles, then lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
  - divu 7/0 -> lo=0xFFFFFFFF, hi=7.
  - div 0x80000000/−1 -> lo=0x80000000, hi=0.
- mthi 1, mtlo 0xFFFFFFFF, then madd 1×1 -> hi=2, lo=0. Then msubu 2×1 -> hi=1, lo=0xFFFFFFFE.
- Start div, with op_d=7 held in D -> stall_d=1 from the start cycle through the final busy cycle. The first mflo after release returns the quotient.
- Start div with HI/LO = 5/6, assert cancel on the 10th busy cycle -> busy=0 next cycle, hi=5, lo=6.
- Assert reset during MUL -> busy=0, hi=lo=0. The result never appears.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO for the E stage.
// Fixed-latency multiply, iterative restoring divide.
module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op_e,
  input  logic [3:0]       op_d,
  input  logic             cancel,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             stall_d,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MTLO  = 4'd1;
  localparam logic [3:0] OP_MTHI  = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_MULT  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MFHI  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] MUL_END = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_END = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t state;

  logic e_mtlo;
  logic e_mthi;
  logic e_mul;
  logic e_div;
  logic e_sdiv;
  logic e_msgn;
  logic e_macc;
  logic e_msub;
  logic e_long;
  logic d_any;
  logic accept;

  logic             m_sgn;
  logic             m_acc;
  logic             m_sub;
  logic             d_sgn;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;

  always_comb begin
    e_mtlo = 1'b0;
    e_mthi = 1'b0;
    e_mul  = 1'b0;
    e_div  = 1'b0;
    e_sdiv = 1'b0;
    e_msgn = 1'b0;
    e_macc = 1'b0;
    e_msub = 1'b0;
    unique case (1'b1)
      op_e == OP_MTLO:  e_mtlo = 1'b1;
      op_e == OP_MTHI:  e_mthi = 1'b1;
      op_e == OP_DIVU:  e_div  = 1'b1;
      op_e == OP_DIV: begin
        e_div  = 1'b1;
        e_sdiv = 1'b1;
      end
      op_e == OP_MULTU: e_mul  = 1'b1;
      op_e == OP_MULT: begin
        e_mul  = 1'b1;
        e_msgn = 1'b1;
      end
      op_e == OP_MADD: begin
        e_mul  = 1'b1;
        e_msgn = 1'b1;
        e_macc = 1'b1;
      end
      op_e == OP_MADDU: begin
        e_mul  = 1'b1;
        e_macc = 1'b1;
      end
      op_e == OP_MSUB: begin
        e_mul  = 1'b1;
        e_msgn = 1'b1;
        e_macc = 1'b1;
        e_msub = 1'b1;
      end
      op_e == OP_MSUBU: begin
        e_mul  = 1'b1;
        e_macc = 1'b1;
        e_msub = 1'b1;
      end
      default: ;
    endcase
  end

  assign e_long  = e_mul | e_div;
  assign d_any   = (op_d >= OP_MTLO) && (op_d <= OP_MSUBU);
  assign accept  = start && !busy && !cancel;
  assign stall_d = d_any && (busy || (start && e_long && !cancel));

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      op_e == OP_MFHI: rdata = hi;
      op_e == OP_MFLO: rdata = lo;
      default: ;
    endcase
  end

  // Divider works on magnitudes; signs are restored in FIX.
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  assign rs_mag = (e_sdiv && rs[WIDTH-1]) ? -rs : rs;
  assign rt_mag = (e_sdiv && rt[WIDTH-1]) ? -rt : rt;

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mul_res;

  assign a_ext   = {{WIDTH{m_sgn & a_r[WIDTH-1]}}, a_r};
  assign b_ext   = {{WIDTH{m_sgn & b_r[WIDTH-1]}}, b_r};
  assign prod    = a_ext * b_ext;
  assign acc     = {hi, lo};
  assign mul_res = !m_acc ? prod :
                   m_sub  ? acc - prod : acc + prod;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_try;
  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;

  assign rem_sh  = {rem_r, quo_r[WIDTH-1]};
  assign rem_try = rem_sh - {1'b0, dvs_r};
  assign q_bit   = ~rem_try[WIDTH];
  assign rem_nx  = q_bit ? rem_try[WIDTH-1:0] : rem_sh[WIDTH-1:0];

  logic             q_neg;
  logic             r_neg;
  logic             div0;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign q_neg = d_sgn & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
  assign r_neg = d_sgn & a_r[WIDTH-1];
  assign div0  = (b_r == '0);
  assign q_fix = div0  ? '1  : (q_neg ? -quo_r : quo_r);
  assign r_fix = div0  ? a_r : (r_neg ? -rem_r : rem_r);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      m_sgn <= 1'b0;
      m_acc <= 1'b0;
      m_sub <= 1'b0;
      d_sgn <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      cnt   <= '0;
      rem_r <= '0;
      quo_r <= '0;
      dvs_r <= '0;
    end else if (cancel && busy) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (e_mtlo) lo <= rs;
            if (e_mthi) hi <= rs;
            if (e_long) begin
              state <= e_mul ? MUL : DIV;
              busy  <= 1'b1;
              m_sgn <= e_msgn;
              m_acc <= e_macc;
              m_sub <= e_msub;
              d_sgn <= e_sdiv;
              a_r   <= rs;
              b_r   <= rt;
              cnt   <= '0;
              rem_r <= '0;
              quo_r <= rs_mag;
              dvs_r <= rt_mag;
            end
          end
        end
        MUL: begin
          if (cnt == MUL_END) begin
            {hi, lo} <= mul_res;
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DIV: begin
          rem_r <= rem_nx;
          quo_r <= {quo_r[WIDTH-2:0], q_bit};
          if (cnt == DIV_END) begin
            state <= FIX;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          hi    <= r_fix;
          lo    <= q_fix;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cancel;
  logic [3:0]  op_e;
  logic [3:0]  op_d;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        stall_d;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  logic [3:0] long_ops [8] = '{4'd3, 4'd4, 4'd5, 4'd6,
                               4'd9, 4'd10, 4'd11, 4'd12};

  md_unit #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op_e(op_e),
    .op_d(op_d),
    .cancel(cancel),
    .rs(rs),
    .rt(rt),
    .busy(busy),
    .stall_d(stall_d),
    .rdata(rdata),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} after the op, from plain arithmetic.
  function automatic logic [63:0] ref_long(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [63:0] acc);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] ps;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = sa * sb;
    pu = {32'd0, a} * {32'd0, b};
    case (op)
      4'd6:  return ps;
      4'd5:  return pu;
      4'd9:  return acc + ps;
      4'd10: return acc + pu;
      4'd11: return acc - ps;
      4'd12: return acc - pu;
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      4'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return acc;
    endcase
  endfunction

  task automatic run_short(input logic [3:0] op, input logic [31:0] v,
                           input string tag);
    start = 1'b1;
    op_e  = op;
    rs    = v;
    tick();
    start = 1'b0;
    op_e  = 4'd0;
    if (op == 4'd2) hi_m = v;
    else lo_m = v;
    chk({tag, " busy"}, {63'd0, busy}, 64'd0);
    chk({tag, " hilo"}, {hi, lo}, {hi_m, lo_m});
  endtask

  task automatic run_long(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
    int n;
    int lat;
    bit stall_ok;
    bit hold_ok;
    logic dstall;
    logic [63:0] exp;
    dstall = (op_d >= 4'd1) && (op_d <= 4'd12);
    exp    = ref_long(op, a, b, {hi_m, lo_m});
    lat    = (op == 4'd3 || op == 4'd4) ? 33 : 5;
    start  = 1'b1;
    op_e   = op;
    rs     = a;
    rt     = b;
    #1;
    chk({tag, " stall_start"}, {63'd0, stall_d}, {63'd0, dstall});
    tick();
    start = 1'b0;
    op_e  = 4'd0;
    rs    = $urandom;
    rt    = $urandom;
    n        = 0;
    stall_ok = 1'b1;
    hold_ok  = 1'b1;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (stall_d !== dstall) stall_ok = 1'b0;
      if ({hi, lo} !== {hi_m, lo_m}) hold_ok = 1'b0;
      tick();
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'(lat));
    chk({tag, " stall_busy"}, {63'd0, stall_ok}, 64'd1);
    chk({tag, " hilo_hold"}, {63'd0, hold_ok}, 64'd1);
    chk({tag, " stall_after"}, {63'd0, stall_d}, 64'd0);
    chk({tag, " hilo"}, {hi, lo}, exp);
    {hi_m, lo_m} = exp;
    op_e = 4'd7;
    #1;
    chk({tag, " mflo"}, {32'd0, rdata}, {32'd0, lo_m});
    op_e = 4'd8;
    #1;
    chk({tag, " mfhi"}, {32'd0, rdata}, {32'd0, hi_m});
    op_e = 4'd0;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          r;
    reset  = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    op_e   = 4'd0;
    op_d   = 4'd0;
    rs     = '0;
    rt     = '0;
    hi_m   = '0;
    lo_m   = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset hilo", {hi, lo}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset stall", {63'd0, stall_d}, 64'd0);
    op_e = 4'd13;
    #1;
    chk("rdata op13", {32'd0, rdata}, 64'd0);
    op_e = 4'd0;

    run_long(4'd6, 32'hFFFF_FFFE, 32'd3, "mult");
    chk("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_long(4'd5, 32'hFFFF_FFFE, 32'd3, "multu");
    chk("multu const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    run_long(4'd4, 32'hFFFF_FFF9, 32'd2, "div");
    chk("div const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_long(4'd3, 32'd7, 32'd0, "divu0");
    chk("divu0 const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    run_long(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, "divmin");
    chk("divmin const", {hi, lo}, 64'h0000_0000_8000_0000);

    run_short(4'd2, 32'd1, "mthi");
    run_short(4'd1, 32'hFFFF_FFFF, "mtlo");
    run_long(4'd9, 32'd1, 32'd1, "madd");
    chk("madd const", {hi, lo}, 64'h0000_0002_0000_0000);
    run_long(4'd12, 32'd2, 32'd1, "msubu");
    chk("msubu const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    op_d = 4'd7;
    run_long(4'd4, 32'd100, 32'd7, "div_stall");
    op_d = 4'd0;

    run_short(4'd2, 32'd5, "mthi5");
    run_short(4'd1, 32'd6, "mtlo6");
    start = 1'b1;
    op_e  = 4'd4;
    rs    = 32'd1000;
    rt    = 32'd3;
    tick();
    start = 1'b0;
    op_e  = 4'd0;
    repeat (9) tick();
    chk("cancel busy10", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel busy", {63'd0, busy}, 64'd0);
    chk("cancel hilo", {hi, lo}, {32'd5, 32'd6});
    repeat (40) tick();
    chk("cancel late", {hi, lo}, {32'd5, 32'd6});

    op_d   = 4'd7;
    start  = 1'b1;
    cancel = 1'b1;
    op_e   = 4'd6;
    rs     = 32'd9;
    rt     = 32'd9;
    #1;
    chk("cancel_start stall", {63'd0, stall_d}, 64'd0);
    tick();
    start  = 1'b0;
    cancel = 1'b0;
    op_e   = 4'd0;
    op_d   = 4'd0;
    chk("cancel_start busy", {63'd0, busy}, 64'd0);
    repeat (6) tick();
    chk("cancel_start hilo", {hi, lo}, {32'd5, 32'd6});

    start = 1'b1;
    op_e  = 4'd6;
    rs    = 32'd3;
    rt    = 32'd4;
    tick();
    start = 1'b0;
    op_e  = 4'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hi_m  = '0;
    lo_m  = '0;
    chk("reset_mul busy", {63'd0, busy}, 64'd0);
    chk("reset_mul hilo", {hi, lo}, 64'd0);
    repeat (10) tick();
    chk("reset_mul late", {hi, lo}, 64'd0);

    for (int i = 0; i < 30; i++) begin
      r    = $urandom_range(0, 9);
      op_d = 4'($urandom_range(0, 15));
      a    = $urandom;
      b    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if (r == 0) begin
        run_short(4'd2, a, "rnd mthi");
      end else if (r == 1) begin
        run_short(4'd1, a, "rnd mtlo");
      end else begin
        op = long_ops[$urandom_range(0, 7)];
        run_long(op, a, b, $sformatf("rnd%0d op%0d", i, op));
      end
    end
    op_d = 4'd0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
